serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 93 +++++++++
 tb/tb_serial_adder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder evaluation per clock, LSB first,
// with the carry held in a flop and the WIDTH-bit result published with a done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, sp;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s, fa_c;
  logic             last;

  // Same behaviour as the shared 1-bit cell: returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  assign {fa_c, fa_s} = full_add(sa[0], sb[0], carry);
  assign last = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Operand load, one bit per RUN edge, result publish on the final bit
  always_ff @(posedge clk) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      sp    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            carry <= cin;
            sp    <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          sp    <= {fa_s, sp[WIDTH-1:1]};
          sa    <= {1'b0, sa[WIDTH-1:1]};
          sb    <= {1'b0, sb[WIDTH-1:1]};
          carry <= fa_c;
          cnt   <= cnt + CNT_W'(1);
          if (last) begin
            sum  <= {fa_s, sp[WIDTH-1:1]};
            cout <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised bench for serial_adder at WIDTH=8 and WIDTH=13.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, cin8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        start13, cin13, busy13, done13, cout13;
  logic [12:0] a13, b13, sum13;

  int checks = 0;
  int errors = 0;
  logic [7:0]  prev8 = '0;
  logic [12:0] prev13 = '0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst), .start(start13), .a(a13), .b(b13), .cin(cin13),
    .busy(busy13), .done(done13), .sum(sum13), .cout(cout13)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts an 8-bit add from the current cycle; returns in the done cycle.
  // keep: leave start high for back-to-back; noisy: toggle inputs during RUN.
  task automatic add8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      input logic [7:0] exp_s, input logic exp_c,
                      input bit keep, input bit noisy);
    int bad;
    bad = 0;
    a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
    tick();
    if (!keep) start8 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (!busy8 || done8 || sum8 !== prev8) bad++;
      if (noisy) begin
        a8 = (i == 4) ? 8'hFF : 8'($urandom);
        b8 = (i == 4) ? 8'hFF : 8'($urandom);
        cin8 = 1'($urandom);
        start8 = (i == 4) ? 1'b1 : 1'($urandom);
      end
      tick();
    end
    if (!keep) start8 = 1'b0;
    check("run8_phase", 32'(bad), 32'd0);
    check("done8_cycle", {30'd0, busy8, done8}, 32'b01);
    check("sum8", 32'(sum8), 32'(exp_s));
    check("cout8", 32'(cout8), 32'(exp_c));
    prev8 = exp_s;
  endtask

  task automatic add13(input logic [12:0] ta, input logic [12:0] tb, input logic tc);
    logic [13:0] e;
    int lat, bad;
    bit seen;
    e = 14'(ta) + 14'(tb) + 14'(tc);
    bad = 0; seen = 0;
    a13 = ta; b13 = tb; cin13 = tc; start13 = 1'b1;
    tick();
    start13 = 1'b0;
    lat = 1;
    while (!seen && lat <= 30) begin
      if (done13) seen = 1;
      else begin
        if (!busy13 || sum13 !== prev13) bad++;
        tick();
        lat++;
      end
    end
    check("lat13", 32'(lat), 32'd14);
    check("run13_phase", 32'(bad), 32'd0);
    check("sum13", 32'(sum13), 32'(e[12:0]));
    check("cout13", 32'(cout13), 32'(e[13]));
    prev13 = e[12:0];
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] re;
    int         bad;

    rst = 1'b1;
    start8 = 0; a8 = '0; b8 = '0; cin8 = 0;
    start13 = 0; a13 = '0; b13 = '0; cin13 = 0;
    tick(); tick();
    check("rst_busy8", 32'(busy8), 0);
    check("rst_done8", 32'(done8), 0);
    check("rst_sum8", 32'(sum8), 0);
    check("rst_cout8", 32'(cout8), 0);
    check("rst_sum13", 32'(sum13), 0);
    rst = 1'b0;
    tick();

    add8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0, 0);
    tick();
    check("done8_width", {30'd0, busy8, done8}, 32'b00);
    tick(); tick();
    check("sum8_hold", 32'(sum8), 32'h96);

    add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 0);
    add8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0, 0);
    add8(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 0, 0);
    tick();

    add8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 0, 1);
    tick(); tick();

    add8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 0, 0);
    tick();
    a8 = 8'hAA; b8 = 8'h55; cin8 = 0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 1; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy8", 32'(busy8), 0);
    check("abort_sum8", 32'(sum8), 0);
    check("abort_cout8", 32'(cout8), 0);
    prev8 = '0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8 || busy8 || sum8 !== 8'h00) bad++;
      tick();
    end
    check("abort_no_done8", 32'(bad), 0);
    add8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0, 0);

    add8(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1, 0);
    add8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1, 0);
    add8(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1, 0);
    add8(8'hC3, 8'h3C, 1'b1, 8'h00, 1'b1, 0, 0);
    tick();

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      re = 9'(ra) + 9'(rb) + 9'(rc);
      add8(ra, rb, rc, re[7:0], re[8], bit'($urandom_range(0, 1)), 0);
    end
    start8 = 1'b0;
    tick();

    add13(13'h1FFF, 13'h0001, 1'b0);
    add13(13'h1FFF, 13'h1FFF, 1'b1);
    for (int n = 0; n < 1000; n++) begin
      add13(13'($urandom), 13'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
